mult_div_unit: RTL

- Iterative 32-bit multiply/divide unit for the multicycle MIPS datapath. It serves MULT, DIV, MFHI and MFLO.
- Sits directly downstream of the A/B operand registers and consumes their outputs.
- Owns the architectural HI and LO registers; their values feed the MemparaReg writeback mux.
- The control unit issues a one-cycle start, holds its state machine in a wait state while busy is high, and resumes on done.

---
 rtl/multdiv_pkg.sv | 24 ++
 rtl/mdu_div_step.sv | 25 ++
 rtl/mult_div_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The optional unsigned operations are enabled by the MULTDIV_UNSIGNED_EN macro.
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_DIV   = 2'b01;
   localparam logic [1:0] OP_MULTU = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam int ITER_DEFAULT = 32;

   function automatic int count_width(input int iter);
      return (iter > 1) ? $clog2(iter) : 1;
   endfunction

   localparam int COUNT_W = count_width(ITER_DEFAULT);

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep the difference if it did not go negative.
module mdu_div_step
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   always_comb begin
      shifted = {rem_in, bit_in};
      trial   = shifted - {1'b0, divisor};
      q_bit   = ~trial[WIDTH];
      rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/DIV unit owning the HI/LO registers of the multicycle MIPS datapath.
// Define MULTDIV_UNSIGNED_EN to add MULTU/DIVU (op[1]=1); otherwise op[1] is ignored.
module mult_div_unit
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = count_width(ITER);

   state_t            state, next_state;
   logic [CW-1:0]     count;
   // {upper partial (WIDTH+1), lower word}: Booth product, or {0, remainder, quotient} for DIV
   logic [2*WIDTH:0]  acc, acc_next;
   logic              booth_prev, booth_prev_next;
   logic [WIDTH:0]    opnd;
   logic              is_div, neg_quo, neg_rem;
   logic [WIDTH:0]    upper;
   logic [WIDTH-1:0]  rem_out;
   logic              q_bit;
   logic [WIDTH-1:0]  result_hi, result_lo;

   logic              start_signed, start_is_div, start_div_zero, a_neg, b_neg;
   logic [WIDTH-1:0]  a_mag, b_mag;

`ifdef MULTDIV_UNSIGNED_EN
   logic run_signed;

   assign start_signed = ~op[1];

   always_ff @(posedge clock) begin
      if (reset)
         run_signed <= 1'b1;
      else if (state == IDLE && start)
         run_signed <= start_signed;
   end
`else
   logic unused_op;

   assign start_signed = 1'b1;
   assign unused_op    = op[1];
`endif

   assign start_is_div   = (op[0] == OP_DIV[0]);
   assign start_div_zero = start_is_div && (b_in == '0);
   assign a_neg          = start_signed & a_in[WIDTH-1];
   assign b_neg          = start_signed & b_in[WIDTH-1];
   assign a_mag          = a_neg ? -a_in : a_in;
   assign b_mag          = b_neg ? -b_in : b_in;

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  (acc[2*WIDTH-1:WIDTH]),
      .bit_in  (acc[WIDTH-1]),
      .divisor (opnd[WIDTH-1:0]),
      .rem_out (rem_out),
      .q_bit   (q_bit)
   );

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start) next_state = start_div_zero ? DONE : RUN;
         RUN:  if (count == CW'(ITER - 1)) next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // One iteration of whichever algorithm is running; the last one feeds HI/LO directly.
   always_comb begin
      acc_next        = acc;
      booth_prev_next = booth_prev;
      upper           = acc[2*WIDTH:WIDTH];
      if (is_div) begin
         acc_next = {1'b0, rem_out, acc[WIDTH-2:0], q_bit};
      end
`ifdef MULTDIV_UNSIGNED_EN
      else if (!run_signed) begin
         if (acc[0]) upper = upper + opnd;
         acc_next = {1'b0, upper, acc[WIDTH-1:1]};
      end
`endif
      else begin
         case ({acc[0], booth_prev})
            2'b01:   upper = upper + opnd;
            2'b10:   upper = upper - opnd;
            default: upper = acc[2*WIDTH:WIDTH];
         endcase
         booth_prev_next = acc[0];
         acc_next        = {upper[WIDTH], upper, acc[WIDTH-1:1]};
      end
   end

   always_comb begin
      if (is_div) begin
         result_lo = neg_quo ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
         result_hi = neg_rem ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
      end else begin
         result_lo = acc_next[WIDTH-1:0];
         result_hi = acc_next[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         hi         <= '0;
         lo         <= '0;
         div_zero   <= 1'b0;
         acc        <= '0;
         booth_prev <= 1'b0;
         opnd       <= '0;
         is_div     <= 1'b0;
         neg_quo    <= 1'b0;
         neg_rem    <= 1'b0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (start) begin
                  count      <= '0;
                  div_zero   <= start_div_zero;
                  is_div     <= start_is_div;
                  booth_prev <= 1'b0;
                  neg_quo    <= a_neg ^ b_neg;
                  neg_rem    <= a_neg;
                  if (start_is_div) begin
                     acc  <= {{(WIDTH+1){1'b0}}, a_mag};
                     opnd <= {1'b0, b_mag};
                  end else begin
                     acc  <= {{(WIDTH+1){1'b0}}, b_in};
                     opnd <= {a_neg, a_in};
                  end
               end
            end
            RUN: begin
               acc        <= acc_next;
               booth_prev <= booth_prev_next;
               count      <= count + CW'(1);
               if (next_state == DONE) begin
                  hi <= result_hi;
                  lo <= result_lo;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
